// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state, command-class and counter-width definitions for bus_ready_gen
package bus_pkg;
  localparam int WAIT_CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, HOLD = 2'b10} state_t;
  typedef enum logic {CLS_IO, CLS_MEM} cls_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous card inputs, reset to RST_VAL
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {2{RST_VAL}};
    else     {q, m} <= {m, d};
endmodule

// File: rtl/bus_ready_gen.sv
// bus_ready_gen: wait-state/READY generator with io_ch_rdy extension; optional timeout via BUS_READY_TIMEOUT_EN
module bus_ready_gen
  import bus_pkg::*;
#(
  parameter int IO_WAITS       = 1,
  parameter int MEM_WAITS      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic aen_n,
  input  logic mrdc_n,
  input  logic amwc_n,
  input  logic iorc_n,
  input  logic aiowc_n,
  input  logic inta_n,
  input  logic io_ch_rdy,
  output logic ready,
  output logic wait_busy,
  output logic bus_timeout
);
  localparam logic [WAIT_CNT_W-1:0] IO_W  = WAIT_CNT_W'(IO_WAITS);
  localparam logic [WAIT_CNT_W-1:0] MEM_W = WAIT_CNT_W'(MEM_WAITS);
  localparam logic [WAIT_CNT_W-1:0] ONE   = WAIT_CNT_W'(1);
  state_t state, state_n;
  cls_t cls;
  logic [WAIT_CNT_W-1:0] count, count_n, ld;
  logic rdy_s, cmd_act, to_hit;
  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(io_ch_rdy), .q(rdy_s));
  assign cmd_act = ~aen_n & ~(mrdc_n & amwc_n & iorc_n & aiowc_n & inta_n);
  assign cls     = (~iorc_n | ~aiowc_n | ~inta_n) ? CLS_IO : CLS_MEM;
  assign ld      = (cls == CLS_IO) ? IO_W : MEM_W;
`ifdef BUS_READY_TIMEOUT_EN
  localparam logic [7:0] TO_W = 8'(TIMEOUT_CYCLES);
  logic [7:0] ext;
  assign to_hit = (state == WAIT) && (count == '0) && !rdy_s && (ext == TO_W);
  always_ff @(posedge clk or posedge rst)
    if (rst) ext <= '0;
    else     ext <= (state != WAIT) ? '0 : ((count == '0) && !rdy_s && !to_hit) ? ext + 8'd1 : ext;
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    count_n = count;
    unique case (state)
      IDLE: if (cmd_act) begin
        state_n = (ld == '0 && rdy_s) ? HOLD : WAIT;
        count_n = (ld == '0) ? '0 : ld - ONE;
      end
      WAIT: if (count != '0) count_n = count - ONE;
            else if (rdy_s || to_hit) state_n = HOLD;
      HOLD: if (!cmd_act) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      ready       <= 1'b1;
      wait_busy   <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      ready       <= state_n != WAIT;
      wait_busy   <= state_n == WAIT;
      bus_timeout <= to_hit;
    end
  always_ff @(posedge clk)
    assert (IO_WAITS >= 0 && IO_WAITS <= 15 && MEM_WAITS >= 0 && MEM_WAITS <= 15 &&
            TIMEOUT_CYCLES >= 1 && TIMEOUT_CYCLES <= 255)
      else $error("bus_ready_gen: wait/timeout parameter out of range, value truncated");
endmodule

// File: tb/tb_bus_ready_gen.sv
// tb_bus_ready_gen: directed checks of bus_ready_gen on three parameter sets sharing one stimulus
module tb_bus_ready_gen;
  import bus_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aen_n = 1'b0, mrdc_n = 1'b1, amwc_n = 1'b1, iorc_n = 1'b1, aiowc_n = 1'b1, inta_n = 1'b1;
  logic io_ch_rdy = 1'b1;
  logic ready0, ready1, ready2, wb0, wb1, wb2, to0, to1, to2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bus_ready_gen u0 (
    .clk(clk), .rst(rst), .aen_n(aen_n), .mrdc_n(mrdc_n), .amwc_n(amwc_n), .iorc_n(iorc_n),
    .aiowc_n(aiowc_n), .inta_n(inta_n), .io_ch_rdy(io_ch_rdy),
    .ready(ready0), .wait_busy(wb0), .bus_timeout(to0));
  bus_ready_gen #(.IO_WAITS(3)) u1 (
    .clk(clk), .rst(rst), .aen_n(aen_n), .mrdc_n(mrdc_n), .amwc_n(amwc_n), .iorc_n(iorc_n),
    .aiowc_n(aiowc_n), .inta_n(inta_n), .io_ch_rdy(io_ch_rdy),
    .ready(ready1), .wait_busy(wb1), .bus_timeout(to1));
  bus_ready_gen #(.TIMEOUT_CYCLES(8)) u2 (
    .clk(clk), .rst(rst), .aen_n(aen_n), .mrdc_n(mrdc_n), .amwc_n(amwc_n), .iorc_n(iorc_n),
    .aiowc_n(aiowc_n), .inta_n(inta_n), .io_ch_rdy(io_ch_rdy),
    .ready(ready2), .wait_busy(wb2), .bus_timeout(to2));

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({ready0, ready1, ready2} !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", {ready0, ready1, ready2}); end
    checks++; if ({wb0, wb1, wb2, to0, to1, to2} !== 6'b0) begin failures++; $display("FAIL reset_busy_to got=%b exp=000000", {wb0, wb1, wb2, to0, to1, to2}); end
    checks++; if (u0.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", u0.state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ready0); end
  endtask

  task automatic test_io_read();
    int lows = 0, busy = 0;
    iorc_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lows += int'(!ready0);
      busy += int'(wb0);
      if (i == 0) begin
        checks++; if ({ready0, wb0} !== 2'b01) begin failures++; $display("FAIL io_first_edge got=%b exp=01", {ready0, wb0}); end
      end
      if (i == 1) begin
        checks++; if (u0.state !== HOLD || ready0 !== 1'b1) begin failures++; $display("FAIL io_hold got=%0d/%b exp=%0d/1", u0.state, ready0, HOLD); end
      end
    end
    iorc_n = 1'b1;
    @(negedge clk);
    checks++; if (u0.state !== IDLE) begin failures++; $display("FAIL io_idle got=%0d exp=%0d", u0.state, IDLE); end
    checks++; if (lows != 1 || busy != 1) begin failures++; $display("FAIL io_low_count got=%0d/%0d exp=1/1", lows, busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mem_zero();
    int lows = 0;
    mrdc_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lows += int'(!ready0) + int'(!ready1);
      if (i == 0) begin
        checks++; if (u0.state !== HOLD) begin failures++; $display("FAIL mem_hold got=%0d exp=%0d", u0.state, HOLD); end
      end
    end
    mrdc_n = 1'b1;
    @(negedge clk);
    checks++; if (u0.state !== IDLE) begin failures++; $display("FAIL mem_idle got=%0d exp=%0d", u0.state, IDLE); end
    checks++; if (lows != 0) begin failures++; $display("FAIL mem_no_wait got=%0d exp=0", lows); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_early_release();
    int lows1 = 1, lows0 = 0;
    aiowc_n = 1'b0;
    @(negedge clk);
    lows0 += int'(!ready0);
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL early_first got=%b exp=0", ready1); end
    aiowc_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lows1 += int'(!ready1);
      lows0 += int'(!ready0);
      if (i == 2) begin
        checks++; if (u1.state !== HOLD || ready1 !== 1'b1) begin failures++; $display("FAIL early_hold got=%0d/%b exp=%0d/1", u1.state, ready1, HOLD); end
      end
      if (i == 3) begin
        checks++; if (u1.state !== IDLE) begin failures++; $display("FAIL early_idle got=%0d exp=%0d", u1.state, IDLE); end
      end
    end
    checks++; if (lows1 != 3) begin failures++; $display("FAIL early_low_count got=%0d exp=3", lows1); end
    checks++; if (lows0 != 1 || u0.state !== IDLE) begin failures++; $display("FAIL drop_in_wait got=%0d/%0d exp=1/%0d", lows0, u0.state, IDLE); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_extension();
    int lows = 0, first_hi = -1;
    io_ch_rdy = 1'b0;
    repeat (2) @(negedge clk);
    iorc_n = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      lows += int'(!ready0);
      if (ready0 && first_hi < 0) first_hi = i;
      if (i == 7) io_ch_rdy = 1'b1;
    end
    checks++; if (lows != 10) begin failures++; $display("FAIL ext_low_count got=%0d exp=10", lows); end
    checks++; if (first_hi != 10) begin failures++; $display("FAIL ext_rise_time got=%0d exp=10", first_hi); end
    iorc_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (u0.state !== IDLE) begin failures++; $display("FAIL ext_idle got=%0d exp=%0d", u0.state, IDLE); end
  endtask

  task automatic test_timeout();
    int lows0 = 0, lows2 = 0, tos = 0, to_at = -1;
    io_ch_rdy = 1'b0;
    repeat (2) @(negedge clk);
    iorc_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lows0 += int'(!ready0);
      lows2 += int'(!ready2);
      if (to2) begin tos++; to_at = i; end
    end
    checks++; if (lows0 != 20 || to0 !== 1'b0) begin failures++; $display("FAIL to_long_limit got=%0d/%b exp=20/0", lows0, to0); end
`ifdef BUS_READY_TIMEOUT_EN
    checks++; if (lows2 != 9) begin failures++; $display("FAIL to_low_count got=%0d exp=9", lows2); end
    checks++; if (tos != 1 || to_at != 9) begin failures++; $display("FAIL to_pulse got=%0d@%0d exp=1@9", tos, to_at); end
`else
    checks++; if (lows2 != 20) begin failures++; $display("FAIL to_unbounded got=%0d exp=20", lows2); end
    checks++; if (tos != 0) begin failures++; $display("FAIL to_tied_zero got=%0d@%0d exp=0", tos, to_at); end
`endif
    io_ch_rdy = 1'b1;
    iorc_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (u0.state !== IDLE || u2.state !== IDLE) begin failures++; $display("FAIL to_recover got=%0d/%0d exp=%0d", u0.state, u2.state, IDLE); end
  endtask

  task automatic test_aen();
    int lows = 0;
    aen_n = 1'b1;
    iorc_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lows += int'(!ready0) + int'(!ready1);
    end
    checks++; if (lows != 0 || u0.state !== IDLE) begin failures++; $display("FAIL aen_ignore got=%0d/%0d exp=0/%0d", lows, u0.state, IDLE); end
    iorc_n = 1'b1;
    aen_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_wait();
    iorc_n = 1'b0;
    @(negedge clk);
    checks++; if (u1.state !== WAIT || ready1 !== 1'b0) begin failures++; $display("FAIL rst_pre got=%0d/%b exp=%0d/0", u1.state, ready1, WAIT); end
    #2 rst = 1'b1;
    #1;
    checks++; if (u1.state !== IDLE || {ready1, wb1, ready0, wb0} !== 4'b1010) begin failures++; $display("FAIL rst_async got=%0d/%b exp=%0d/1010", u1.state, {ready1, wb1, ready0, wb0}, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    iorc_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready1 !== 1'b1 || u1.state !== IDLE) begin failures++; $display("FAIL rst_release got=%b/%0d exp=1/%0d", ready1, u1.state, IDLE); end
  endtask

  task automatic test_back_to_back();
    int lows = 0;
    iorc_n = 1'b0;
    repeat (2) begin @(negedge clk); lows += int'(!ready0); end
    iorc_n = 1'b1;
    @(negedge clk);
    checks++; if (u0.state !== IDLE) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", u0.state, IDLE); end
    inta_n = 1'b0;
    @(negedge clk);
    lows += int'(!ready0);
    checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL b2b_inta_wait got=%b exp=0", ready0); end
    @(negedge clk);
    lows += int'(!ready0);
    inta_n = 1'b1;
    @(negedge clk);
    checks++; if (lows != 2 || u0.state !== IDLE) begin failures++; $display("FAIL b2b_total got=%0d/%0d exp=2/%0d", lows, u0.state, IDLE); end
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_mem_zero();
    test_early_release();
    test_extension();
    test_timeout();
    test_aen();
    test_rst_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
